// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - frame constants and FSM encoding shared by adc_sample_capture
package adc_capture_pkg;

    // ADC121S101-class frame: 16 sclk periods, 4 leading zeros, 12-bit code MSB first
    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int ADC_BITS   = 12;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_START_ENC = 2'd1;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_START = ST_START_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/adc_sample_capture_tick_gen.sv
// rtl/adc_sample_capture_tick_gen.sv - modulo-N counter with enable and one-cycle tick
module tick_gen #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count 0..N-1 while enabled; a low enable parks the count at zero
    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                tick = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sample_capture.sv
// rtl/adc_sample_capture.sv - sample-rate paced serial ADC reader; ADC_BUSY_CHECK_EN adds overrun detection
module adc_sample_capture
    import adc_capture_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2268,
    parameter int DATA_W        = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              adc_sdata,
    input  logic              ocupado,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] muestra,
    output logic              datolisto,
    output logic              desborde
);

    localparam int BIT_W = $clog2(FRAME_BITS);

    state_t              state_q, state_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [ADC_BITS-1:0] code_q, code_d;
    logic [DATA_W-1:0]   muestra_q, muestra_d;
    logic                datolisto_q, datolisto_d;
    logic                desborde_q, desborde_d;

    logic sample_tick;
    logic half_tick;
    logic half_en;

    // The half-period divider only runs while the frame is being clocked
    assign half_en = (state_q == ST_START) || (state_q == ST_SHIFT);

    tick_gen #(.N(SAMPLE_PERIOD)) u_sample_tick (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .tick  (sample_tick)
    );

    tick_gen #(.N(CLK_DIV)) u_half_tick (
        .clk   (clk),
        .reset (reset),
        .en    (half_en),
        .tick  (half_tick)
    );

`ifndef ADC_BUSY_CHECK_EN
    logic ocupado_unused;
    assign ocupado_unused = ocupado;
`endif

    // Frame sequencing, serial capture and sample conversion
    always_comb begin
        state_d     = state_q;
        sclk_d      = sclk_q;
        bit_d       = bit_q;
        code_d      = code_q;
        muestra_d   = muestra_q;
        datolisto_d = 1'b0;
        desborde_d  = desborde_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b1;
                if (sample_tick) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                    code_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (half_tick) begin
                    if (!sclk_q) begin
                        // Rising sclk edge: the ADC data has been stable for the whole low half
                        sclk_d = 1'b1;
                        if (bit_q >= BIT_W'(LEAD_ZEROS)) begin
                            code_d = {code_q[ADC_BITS-2:0], adc_sdata};
                        end
                    end else if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        // Last high half done; sclk stays high into DONE/IDLE
                        state_d   = ST_DONE;
                        muestra_d = '0;
                        muestra_d[DATA_W-1 -: ADC_BITS] = {~code_q[ADC_BITS-1], code_q[ADC_BITS-2:0]};
`ifdef ADC_BUSY_CHECK_EN
                        datolisto_d = !ocupado;
                        if (ocupado) begin
                            desborde_d = 1'b1;
                        end
`else
                        datolisto_d = 1'b1;
`endif
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cs_n_d = !((state_d == ST_START) || (state_d == ST_SHIFT));
    end

    // State and output registers; reset abandons any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sclk_q      <= 1'b1;
            cs_n_q      <= 1'b1;
            bit_q       <= '0;
            code_q      <= '0;
            muestra_q   <= '0;
            datolisto_q <= 1'b0;
            desborde_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            bit_q       <= bit_d;
            code_q      <= code_d;
            muestra_q   <= muestra_d;
            datolisto_q <= datolisto_d;
            desborde_q  <= desborde_d;
        end
    end

    assign adc_cs_n  = cs_n_q;
    assign adc_sclk  = sclk_q;
    assign muestra   = muestra_q;
    assign datolisto = datolisto_q;
    assign desborde  = desborde_q;

endmodule
